// File: rtl/mgt_reset_sequencer_tmr.sv
// Reset/bring-up sequencer for a shared TX PLL and NUM_LINKS transmitters, clock_40 domain.
// Define MGT_RESET_SEQ_TMR_EN to triplicate all state with bitwise majority voting.
module mgt_reset_sequencer_tmr #(
   parameter int NUM_LINKS        = 4,
   parameter int PLL_RESET_CYCLES = 16,
   parameter int LOCK_TIMEOUT     = 4000,
   parameter int MGT_RESET_CYCLES = 8,
   parameter int REALIGN_CYCLES   = 4,
   parameter int ALLOW_RETRY      = 1
) (
   input  logic                 clock_40,
   input  logic                 reset_n_i,
   input  logic                 mgt_startup_done_i,
   input  logic                 pll_lock_i,
   input  logic [NUM_LINKS-1:0] tx_reset_done_i,
   input  logic                 ext_pll_reset_i,
   input  logic [NUM_LINKS-1:0] ext_mgt_reset_i,
   input  logic                 ext_txpowerdown_i,
   input  logic [1:0]           ext_txpowerdown_mode_i,
   input  logic                 force_not_ready_i,
   output logic                 pll_reset_o,
   output logic [NUM_LINKS-1:0] mgt_reset_o,
   output logic                 txreset_o,
   output logic                 mgt_realign_o,
   output logic                 txpowerdown_o,
   output logic [1:0]           txpowerdown_mode_o,
   output logic [NUM_LINKS-1:0] ready_o,
   output logic                 all_ready_o,
   output logic [7:0]           retry_count_o,
   output logic                 fail_o,
   output logic [2:0]           state_o,
   output logic                 tmr_err_o
);

   localparam int MAX_A = (PLL_RESET_CYCLES > LOCK_TIMEOUT) ? PLL_RESET_CYCLES : LOCK_TIMEOUT;
   localparam int MAX_B = (MGT_RESET_CYCLES > REALIGN_CYCLES) ? MGT_RESET_CYCLES : REALIGN_CYCLES;
   localparam int CW    = $clog2(((MAX_A > MAX_B) ? MAX_A : MAX_B) + 1);
   localparam int SW    = $clog2(MGT_RESET_CYCLES + 1);

   typedef enum logic [2:0] {
      WAIT_STARTUP = 3'd0,
      PLL_RESET    = 3'd1,
      WAIT_LOCK    = 3'd2,
      MGT_RESET    = 3'd3,
      WAIT_DONE    = 3'd4,
      REALIGN      = 3'd5,
      READY        = 3'd6,
      FAIL         = 3'd7
   } state_e;

   // Every bit of state lives in one packed record so it can be replicated and voted as a whole.
   typedef struct packed {
      logic [2:0]                    state;
      logic [CW-1:0]                 cnt;
      logic [7:0]                    retry;
      logic                          ext_pll;
      logic [NUM_LINKS-1:0]          ext_mgt;
      logic [NUM_LINKS-1:0][SW-1:0]  stretch;
      logic [NUM_LINKS-1:0]          ready;
      logic                          pd;
      logic [1:0]                    pd_mode;
   } regs_t;

   localparam int RW = $bits(regs_t);
`ifdef MGT_RESET_SEQ_TMR_EN
   localparam int NCOPY = 3;
`else
   localparam int NCOPY = 1;
`endif

   (* dont_touch = "true" *) regs_t regs_q [NCOPY];
   regs_t                regs_d;
   regs_t                voted;
   logic                 pll_edge;
   logic [NUM_LINKS-1:0] mgt_edge;
   logic                 timeout;
   logic                 go_pll;
   logic [7:0]           retry_inc;
   logic                 hold_mgt;

`ifdef MGT_RESET_SEQ_TMR_EN
   (* dont_touch = "true" *) logic [RW-1:0] voted_bits;
   logic [RW-1:0] copy_a, copy_b, copy_c;
   logic          disagree;
   logic          tmr_err_q;

   assign copy_a = regs_q[0];
   assign copy_b = regs_q[1];
   assign copy_c = regs_q[2];

   generate
      for (genvar gi = 0; gi < RW; gi++) begin : g_vote
         assign voted_bits[gi] = (copy_a[gi] & copy_b[gi]) | (copy_a[gi] & copy_c[gi]) |
                                 (copy_b[gi] & copy_c[gi]);
      end
   endgenerate

   assign disagree = |((copy_a ^ copy_b) | (copy_a ^ copy_c));

   always_ff @(posedge clock_40 or negedge reset_n_i) begin
      if (!reset_n_i) tmr_err_q <= 1'b0;
      else            tmr_err_q <= disagree;
   end
   assign tmr_err_o = tmr_err_q;
`else
   logic [RW-1:0] voted_bits;
   assign voted_bits = regs_q[0];
   assign tmr_err_o  = 1'b0;
`endif

   assign voted = regs_t'(voted_bits);

   // All copies load the same next state computed from the vote, so an upset copy heals in one clock.
   always_ff @(posedge clock_40 or negedge reset_n_i) begin
      if (!reset_n_i) begin
         for (int c = 0; c < NCOPY; c++) regs_q[c] <= '0;
      end else begin
         for (int c = 0; c < NCOPY; c++) regs_q[c] <= regs_d;
      end
   end

   assign pll_edge  = ext_pll_reset_i & ~voted.ext_pll;
   assign mgt_edge  = ext_mgt_reset_i & ~voted.ext_mgt;
   assign timeout   = (voted.cnt == CW'(LOCK_TIMEOUT - 1));
   assign retry_inc = (voted.retry == 8'hFF) ? 8'hFF : voted.retry + 8'd1;

   always_comb begin
      regs_d         = voted;
      go_pll         = 1'b0;
      regs_d.ext_pll = ext_pll_reset_i;
      regs_d.ext_mgt = ext_mgt_reset_i;
      regs_d.pd      = ext_txpowerdown_i;
      regs_d.pd_mode = ext_txpowerdown_mode_i;
      for (int i = 0; i < NUM_LINKS; i++) begin
         if (voted.stretch[i] != '0) regs_d.stretch[i] = voted.stretch[i] - 1'b1;
         regs_d.ready[i] = (voted.state == READY) & tx_reset_done_i[i] &
                           (voted.stretch[i] == '0) & ~force_not_ready_i;
      end
      case (voted.state)
         WAIT_STARTUP: if (mgt_startup_done_i) go_pll = 1'b1;
         PLL_RESET: begin
            if (voted.cnt == CW'(PLL_RESET_CYCLES - 1)) begin
               regs_d.state = WAIT_LOCK;
               regs_d.cnt   = '0;
            end else regs_d.cnt = voted.cnt + 1'b1;
         end
         WAIT_LOCK: begin
            if (pll_lock_i) begin
               regs_d.state = MGT_RESET;
               regs_d.cnt   = '0;
            end else if (timeout) begin
               if (ALLOW_RETRY != 0) begin
                  regs_d.retry = retry_inc;
                  go_pll       = 1'b1;
               end else begin
                  regs_d.state = FAIL;
                  regs_d.cnt   = '0;
               end
            end else regs_d.cnt = voted.cnt + 1'b1;
         end
         MGT_RESET: begin
            if (voted.cnt == CW'(MGT_RESET_CYCLES - 1)) begin
               regs_d.state = WAIT_DONE;
               regs_d.cnt   = '0;
            end else regs_d.cnt = voted.cnt + 1'b1;
         end
         WAIT_DONE: begin
            // Any low lock level here (not only a fresh falling edge) means the PLL is gone.
            if (!pll_lock_i) go_pll = 1'b1;
            else if (&tx_reset_done_i) begin
               regs_d.state = REALIGN;
               regs_d.cnt   = '0;
            end else if (timeout) begin
               if (ALLOW_RETRY != 0) begin
                  regs_d.retry = retry_inc;
                  go_pll       = 1'b1;
               end else begin
                  regs_d.state = FAIL;
                  regs_d.cnt   = '0;
               end
            end else regs_d.cnt = voted.cnt + 1'b1;
         end
         REALIGN: begin
            if (voted.cnt == CW'(REALIGN_CYCLES - 1)) begin
               regs_d.state = READY;
               regs_d.cnt   = '0;
            end else regs_d.cnt = voted.cnt + 1'b1;
         end
         READY: begin
            if (!pll_lock_i) begin
               regs_d.retry = retry_inc;
               go_pll       = 1'b1;
            end else begin
               for (int i = 0; i < NUM_LINKS; i++)
                  if (mgt_edge[i]) regs_d.stretch[i] = SW'(MGT_RESET_CYCLES);
            end
         end
         default: ;
      endcase
      // A software restart overrides everything else and leaves the retry count alone.
      if (pll_edge && (voted.state != WAIT_STARTUP)) begin
         go_pll       = 1'b1;
         regs_d.retry = voted.retry;
      end
      if (go_pll) begin
         regs_d.state   = PLL_RESET;
         regs_d.cnt     = '0;
         regs_d.stretch = '0;
      end
   end

   assign hold_mgt = (voted.state == WAIT_STARTUP) || (voted.state == MGT_RESET);

   generate
      for (genvar gi = 0; gi < NUM_LINKS; gi++) begin : g_link
         assign mgt_reset_o[gi] = hold_mgt | (voted.stretch[gi] != '0);
      end
   endgenerate

   assign pll_reset_o        = (voted.state == WAIT_STARTUP) || (voted.state == PLL_RESET) ||
                               (voted.state == FAIL);
   assign txreset_o          = hold_mgt;
   assign mgt_realign_o      = (voted.state == REALIGN);
   assign txpowerdown_o      = voted.pd;
   assign txpowerdown_mode_o = voted.pd_mode;
   assign ready_o            = voted.ready;
   assign all_ready_o        = &voted.ready;
   assign retry_count_o      = voted.retry;
   assign fail_o             = (voted.state == FAIL);
   assign state_o            = voted.state;

endmodule
